// File: rtl/perf_counter_bank.sv
// perf_counter_bank: CSR-mapped bank of event counters with sticky overflow flags and a tear-free high-word snapshot
// Ports: clk; rst (asynchronous, active-low); events (per-channel single-cycle count pulses);
//        rEn/rAddr -> rData/rValid (registered, one-cycle read); wEn/wAddr/wData (CSR write);
//        overflow (sticky wrap flags, W1C at address 29); irq (registered OR of uninhibited overflow flags)
module perf_counter_bank #(
    parameter int NUM_CNT = 4,
    parameter int CNT_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CNT-1:0] events,
    input  logic               rEn,
    input  logic [4:0]         rAddr,
    output logic [31:0]        rData,
    output logic               rValid,
    input  logic               wEn,
    input  logic [4:0]         wAddr,
    input  logic [31:0]        wData,
    output logic [NUM_CNT-1:0] overflow,
    output logic               irq
);
    logic [NUM_CNT-1:0] inhibit, wrapSet, ovfClr;
    logic [31:0] loWord [16];
    logic [31:0] hiWord [16];
    logic [31:0] shadowHi, rdMux, shadowNext;
    logic cntSel;

    // Counters are viewed zero-extended to 64 bits so both halves exist for any CNT_W.
    for (genvar k = 0; k < 16; k++) begin : gCh
        if (k < NUM_CNT) begin : gCnt
            logic [CNT_W-1:0] c;
            logic [63:0] cur;
            logic wHit, inc;
            assign cur = 64'(c);
            assign wHit = wEn && wAddr[4:1] == 4'(k);
            // A CSR write to either half takes precedence over counting.
            assign inc = events[k] && !inhibit[k] && !wHit;
            assign wrapSet[k] = inc && &c;
            assign loWord[k] = cur[31:0];
            assign hiWord[k] = cur[63:32];
            always_ff @(posedge clk or negedge rst)
                if (!rst) c <= '0;
                else if (wHit) c <= CNT_W'(wAddr[0] ? {wData, cur[31:0]} : {cur[63:32], wData});
                else if (inc) c <= c + CNT_W'(1);
        end else begin : gNone
            assign loWord[k] = '0;
            assign hiWord[k] = '0;
        end
    end

    // Addresses 28..31 map to index 14/15, which is never a live channel.
    assign cntSel = int'(rAddr[4:1]) < NUM_CNT;
    assign ovfClr = (wEn && wAddr == 5'd29) ? wData[NUM_CNT-1:0] : '0;
    assign rdMux = rAddr == 5'd28 ? 32'(inhibit) :
                   rAddr == 5'd29 ? 32'(overflow) :
                   !cntSel ? '0 :
                   rAddr[0] ? shadowHi : loWord[rAddr[4:1]];
    // Reading the low half latches the matching high half so a later high read is consistent.
    assign shadowNext = (rEn && cntSel && !rAddr[0]) ? hiWord[rAddr[4:1]] : shadowHi;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            inhibit <= '0;
            overflow <= '0;
            shadowHi <= '0;
            rData <= '0;
            rValid <= 1'b0;
            irq <= 1'b0;
        end else begin
            rValid <= rEn;
            if (rEn) rData <= rdMux;
            shadowHi <= shadowNext;
            if (wEn && wAddr == 5'd28) inhibit <= wData[NUM_CNT-1:0];
            // Clearing wins over a wrap in the same cycle.
            overflow <= (overflow | wrapSet) & ~ovfClr;
            irq <= |(overflow & ~inhibit);
        end
endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] events = '0;
    logic rEn = 1'b0, wEn = 1'b0;
    logic [4:0] rAddr = '0, wAddr = '0;
    logic [31:0] wData = '0;
    logic [31:0] rData;
    logic rValid, irq;
    logic [3:0] overflow;

    logic [0:0] evB = '0;
    logic [0:0] ovB;
    logic rEnB = 1'b0;
    logic [4:0] rAddrB = '0;
    logic [31:0] rDataB;
    logic rValidB, irqB;

    perf_counter_bank dut (
        .clk(clk), .rst(rst), .events(events), .rEn(rEn), .rAddr(rAddr), .rData(rData),
        .rValid(rValid), .wEn(wEn), .wAddr(wAddr), .wData(wData), .overflow(overflow), .irq(irq)
    );

    perf_counter_bank #(.NUM_CNT(1), .CNT_W(8)) dutB (
        .clk(clk), .rst(rst), .events(evB), .rEn(rEnB), .rAddr(rAddrB), .rData(rDataB),
        .rValid(rValidB), .wEn(1'b0), .wAddr(5'd0), .wData(32'd0), .overflow(ovB), .irq(irqB)
    );

    int tests = 0;
    int fails = 0;

    longint unsigned mCnt [4];
    logic [3:0] mInh, mOv;
    logic [31:0] mShadow;
    logic mIrq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mReset();
        for (int k = 0; k < 4; k++) mCnt[k] = 0;
        mInh = '0;
        mOv = '0;
        mShadow = '0;
        mIrq = 1'b0;
    endtask

    function automatic logic [31:0] mRead(input logic [4:0] a);
        if (a == 5'd28) return {28'd0, mInh};
        if (a == 5'd29) return {28'd0, mOv};
        if (a < 5'd8) return a[0] ? mShadow : mCnt[a >> 1][31:0];
        return 32'd0;
    endfunction

    task automatic step(input logic [3:0] ev, input logic re, input logic [4:0] ra,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic [31:0] expRd;
        logic irqN;
        events = ev; rEn = re; rAddr = ra; wEn = we; wAddr = wa; wData = wd;
        expRd = mRead(ra);
        irqN = |(mOv & ~mInh);
        if (re && ra < 5'd8 && !ra[0]) mShadow = mCnt[ra >> 1][63:32];
        for (int k = 0; k < 4; k++) begin
            if (we && wa < 5'd8 && int'(wa >> 1) == k) begin
                if (wa[0]) mCnt[k] = {wd, mCnt[k][31:0]};
                else mCnt[k] = {mCnt[k][63:32], wd};
            end else if (ev[k] && !mInh[k]) begin
                if (mCnt[k] == 64'hFFFF_FFFF_FFFF_FFFF) mOv[k] = 1'b1;
                mCnt[k] = mCnt[k] + 1;
            end
        end
        if (we && wa == 5'd28) mInh = wd[3:0];
        if (we && wa == 5'd29) mOv = mOv & ~wd[3:0];
        mIrq = irqN;
        @(posedge clk);
        #1;
        chk("rValid", rValid, re);
        if (re) chk("rData", rData, expRd);
        chk("overflow", overflow, mOv);
        chk("irq", irq, mIrq);
        events = '0; rEn = 1'b0; wEn = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        step(4'h0, 1'b1, a, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        step(4'h0, 1'b0, 5'd0, 1'b1, a, d);
    endtask

    initial begin
        mReset();
        #12;
        chk("rstRData", rData, 0);
        chk("rstRValid", rValid, 0);
        chk("rstOverflow", overflow, 0);
        chk("rstIrq", irq, 0);
        chk("rstRDataB", rDataB, 0);
        chk("rstOvB", ovB, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        repeat (10) step(4'h1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        rd(5'd0);
        chk("count10", rData, 10);
        rd(5'd1);
        chk("count10Hi", rData, 0);

        wr(5'd1, 32'hFFFF_FFFF);
        wr(5'd0, 32'hFFFF_FFFE);
        step(4'h1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        step(4'h1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        chk("wrapOvf", overflow[0], 1);
        chk("wrapIrqLate", irq, 0);
        rd(5'd0);
        chk("wrapIrq", irq, 1);
        chk("wrapLo", rData, 0);
        rd(5'd1);
        chk("wrapHi", rData, 0);
        wr(5'd29, 32'h1);

        wr(5'd2, 32'hFFFF_FFFF);
        rd(5'd2);
        step(4'h2, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        rd(5'd3);
        chk("snapHi", rData, 0);
        rd(5'd2);
        rd(5'd3);
        chk("snapHiLive", rData, 1);

        wr(5'd3, 32'hFFFF_FFFF);
        wr(5'd2, 32'hFFFF_FFFF);
        step(4'h2, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        wr(5'd28, 32'h2);
        repeat (5) step(4'h3, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        chk("inhIrq", irq, 0);
        chk("inhOvf", overflow, 4'h2);
        rd(5'd0);
        chk("inhCh0", rData, 5);
        rd(5'd2);
        chk("inhCh1", rData, 0);
        wr(5'd28, 32'h0);
        wr(5'd29, 32'hF);

        step(4'h1, 1'b0, 5'd0, 1'b1, 5'd0, 32'h100);
        rd(5'd0);
        chk("wrBeatsInc", rData, 32'h100);
        wr(5'd1, 32'hFFFF_FFFF);
        wr(5'd0, 32'hFFFF_FFFF);
        step(4'h1, 1'b0, 5'd0, 1'b1, 5'd29, 32'h1);
        chk("w1cBeatsWrap", overflow[0], 0);
        step(4'h0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h55);
        chk("rdPreWrite", rData, 0);
        rd(5'd0);
        chk("rdPostWrite", rData, 32'h55);

        step(4'h1, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("midRstRValid", rValid, 0);
        chk("midRstRData", rData, 0);
        mReset();
        #3 rst = 1'b1;
        rd(5'd0);
        chk("postRstCnt", rData, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            d = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
            step(4'($urandom), 1'($urandom), 5'($urandom_range(0, 31)),
                 $urandom_range(0, 5) == 0, 5'($urandom_range(0, 31)), d);
        end

        evB = 1'b1;
        repeat (255) @(posedge clk);
        #1;
        evB = 1'b0;
        rEnB = 1'b1;
        rAddrB = 5'd0;
        @(posedge clk);
        #1;
        chk("swp255", rDataB, 255);
        chk("swpOv0", ovB, 0);
        rEnB = 1'b0;
        evB = 1'b1;
        @(posedge clk);
        #1;
        evB = 1'b0;
        chk("swpOv1", ovB, 1);
        rEnB = 1'b1;
        @(posedge clk);
        #1;
        chk("swpLo", rDataB, 0);
        chk("swpValid", rValidB, 1);
        chk("swpIrq", irqB, 1);
        rAddrB = 5'd1;
        @(posedge clk);
        #1;
        chk("swpHi", rDataB, 0);
        rAddrB = 5'd2;
        @(posedge clk);
        #1;
        chk("swpAddr2", rDataB, 0);
        rEnB = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
